sdr_wr_fsm: RTL and testbench

Write-side state machine of the SDRAM controller, the counterpart of the read FSM. It accepts one 32-bit write request with a row, column and bank address. It issues ACTIVE, then WRITE with auto-precharge, then drives a two-beat 16-bit burst (low half first) onto the SDRAM data pins. It waits write-recovery plus precharge time and then signals completion. Its command/address bus is muxed with the read and refresh buses by the controller's arbiter.

---
 rtl/sdr_wr_fsm_pkg.sv | 49 ++++
 rtl/sdr_wr_dq_drv.sv | 86 ++++++++
 rtl/sdr_wr_fsm.sv | 191 +++++++++++++++++++
 tb/tb_sdr_wr_fsm.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_wr_fsm_pkg.sv
// sdr_wr_fsm_pkg
//   Shared definitions for the SDRAM write-side state machine:
//   - SDRAM command encodings {cs_n, ras_n, cas_n, we_n}
//   - wr_bus field layout {cmd[3:0], a[12:0], ba[1:0], cke}
//   - default timing constants used as the FSM parameter defaults
//   - FSM state encoding and a small bus-packing helper
package sdr_wr_fsm_pkg;

  // Command encodings, active-low {cs_n, ras_n, cas_n, we_n}.
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;

  // wr_bus field widths.
  localparam int CMD_W  = 4;
  localparam int ADDR_W = 13;
  localparam int BA_W   = 2;
  localparam int CKE_W  = 1;
  localparam int BUS_W  = CMD_W + ADDR_W + BA_W + CKE_W;

  // Data path widths.
  localparam int DQ_W    = 16;
  localparam int WDATA_W = 32;
  localparam int COL_W   = 10;

  // Default timing, in clk cycles.
  localparam int TRCD_DEF = 2;
  localparam int TWR_DEF  = 2;
  localparam int TRP_DEF  = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACT   = 3'd1,
    S_RCD   = 3'd2,
    S_WRL   = 3'd3,
    S_WRH   = 3'd4,
    S_RECOV = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Assemble the arbiter bus; cke is always high outside of the SDRAM
  // power-down modes, which this controller never uses.
  function automatic logic [BUS_W-1:0] pack_bus(input logic [CMD_W-1:0]  cmd,
                                                input logic [ADDR_W-1:0] a,
                                                input logic [BA_W-1:0]   bank);
    return {cmd, a, bank, 1'b1};
  endfunction

endpackage

// File: rtl/sdr_wr_dq_drv.sv
// sdr_wr_dq_drv
//   Registered SDRAM data-pin driver for the write FSM.
//   load_l : drive beat 0 (wdata[15:0]) on the next cycle, oe high
//   load_h : drive beat 1 (wdata[31:16]) on the next cycle, oe high
//   neither: oe low, sdr_dq_o holds its last value
// Ports:
//   clk, soft_rst   clock and synchronous active-high reset
//   load_l, load_h  beat strobes from the FSM (never both high)
//   wdata           captured 32-bit write word
//   wr_be           captured byte enables (only with SDR_WR_DQM_EN)
//   sdr_dq_o        data to SDRAM pins
//   sdr_dq_oe       tristate enable
//   sdr_dqm         byte masks, active high (only with SDR_WR_DQM_EN)
// Optional feature macro: SDR_WR_DQM_EN.
module sdr_wr_dq_drv
  import sdr_wr_fsm_pkg::*;
(
  input  logic               clk,
  input  logic               soft_rst,
  input  logic               load_l,
  input  logic               load_h,
  input  logic [WDATA_W-1:0] wdata,
`ifdef SDR_WR_DQM_EN
  input  logic [3:0]         wr_be,
  output logic [1:0]         sdr_dqm,
`endif
  output logic [DQ_W-1:0]    sdr_dq_o,
  output logic               sdr_dq_oe
);

  logic [DQ_W-1:0] dq_reg;
  logic [DQ_W-1:0] dq_next;
  logic            oe_reg;
  logic            oe_next;

  always_comb begin
    dq_next = dq_reg;
    oe_next = 1'b0;
    if (load_l) begin
      dq_next = wdata[DQ_W-1:0];
      oe_next = 1'b1;
    end else if (load_h) begin
      dq_next = wdata[WDATA_W-1:DQ_W];
      oe_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      dq_reg <= '0;
      oe_reg <= 1'b0;
    end else begin
      dq_reg <= dq_next;
      oe_reg <= oe_next;
    end
  end

  assign sdr_dq_o  = dq_reg;
  assign sdr_dq_oe = oe_reg;

`ifdef SDR_WR_DQM_EN
  // One mask bit per byte lane; a lane is masked when its enable is low.
  logic [1:0] dqm_reg;
  logic [1:0] dqm_next;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dqm_lane
    always_comb begin
      dqm_next[gi] = 1'b0;
      if (load_l)
        dqm_next[gi] = ~wr_be[gi];
      else if (load_h)
        dqm_next[gi] = ~wr_be[2+gi];
    end
  end

  always_ff @(posedge clk) begin
    if (soft_rst)
      dqm_reg <= 2'b00;
    else
      dqm_reg <= dqm_next;
  end

  assign sdr_dqm = dqm_reg;
`endif

endmodule

// File: rtl/sdr_wr_fsm.sv
// sdr_wr_fsm
//   Write-side SDRAM state machine. Accepts one 32-bit write, issues
//   ACTIVE, then WRITE with auto-precharge together with a two-beat
//   16-bit burst (low half first), waits tWR + tRP and pulses wr_done.
// Ports:
//   clk, soft_rst  clock and synchronous active-high reset
//   wr_en          level request, sampled only in IDLE
//   wr_done        one-cycle completion pulse
//   row, col, ba   SDRAM address of the write
//   wdata          [15:0] beat 0, [31:16] beat 1
//   wr_bus         {cmd[3:0], a[12:0], ba[1:0], cke} to the arbiter
//   sdr_dq_o       data to the SDRAM pins
//   sdr_dq_oe      tristate enable for sdr_dq_o
//   wr_be, sdr_dqm byte enables / byte masks (only with SDR_WR_DQM_EN)
// Parameters T_RCD, T_WR, T_RP: cycles, legal range 1..7 each.
// Optional feature macro: SDR_WR_DQM_EN.
module sdr_wr_fsm
  import sdr_wr_fsm_pkg::*;
#(
  parameter int T_RCD = TRCD_DEF,
  parameter int T_WR  = TWR_DEF,
  parameter int T_RP  = TRP_DEF
) (
  input  logic               clk,
  input  logic               soft_rst,
  input  logic               wr_en,
  output logic               wr_done,
  input  logic [ADDR_W-1:0]  row,
  input  logic [COL_W-1:0]   col,
  input  logic [BA_W-1:0]    ba,
  input  logic [WDATA_W-1:0] wdata,
`ifdef SDR_WR_DQM_EN
  input  logic [3:0]         wr_be,
  output logic [1:0]         sdr_dqm,
`endif
  output logic [BUS_W-1:0]   wr_bus,
  output logic [DQ_W-1:0]    sdr_dq_o,
  output logic               sdr_dq_oe
);

  // RCD lasts T_RCD-1 cycles; RECOV lasts T_WR+T_RP cycles.
  localparam logic [3:0] RCD_LAST = (T_RCD > 1) ? 4'(T_RCD - 2) : 4'd0;
  localparam logic [3:0] REC_LAST = 4'(T_WR + T_RP - 1);

  state_t             state_reg, state_next;
  logic [3:0]         cnt_reg, cnt_next;

  // Captured request. The row is only needed on the ACT cycle, which is
  // issued straight from the acceptance edge, so a_reg serves as its copy.
  logic [COL_W-1:0]   col_reg;
  logic [BA_W-1:0]    ba_reg;
  logic [WDATA_W-1:0] wdata_reg;
  logic               capture;

  // Registered command/address outputs.
  logic [CMD_W-1:0]   cmd_reg, cmd_next;
  logic [ADDR_W-1:0]  a_reg, a_next;
  logic [BA_W-1:0]    bao_reg, bao_next;
  logic               done_reg, done_next;

  logic               enter_wrl;
  logic               load_l;
  logic               load_h;

  // Outputs are registered, so everything below decodes the state being
  // entered: the command for a state appears in the same cycle as the state.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cmd_next   = CMD_NOP;
    a_next     = '0;
    bao_next   = '0;
    done_next  = 1'b0;
    capture    = 1'b0;
    enter_wrl  = 1'b0;
    load_h     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (wr_en) begin
          capture    = 1'b1;
          state_next = S_ACT;
          cmd_next   = CMD_ACT;
          a_next     = row;
          bao_next   = ba;
        end
      end
      S_ACT: begin
        if (T_RCD == 1)
          enter_wrl = 1'b1;
        else
          state_next = S_RCD;
      end
      S_RCD: begin
        if (cnt_reg == RCD_LAST)
          enter_wrl = 1'b1;
        else
          cnt_next = cnt_reg + 4'd1;
      end
      S_WRL: begin
        state_next = S_WRH;
        load_h     = 1'b1;
      end
      S_WRH: begin
        state_next = S_RECOV;
      end
      S_RECOV: begin
        if (cnt_reg == REC_LAST) begin
          state_next = S_DONE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // WRITE with auto-precharge (a[10]=1); write latency 0 means the low
    // beat goes out in the same cycle as the command.
    if (enter_wrl) begin
      state_next = S_WRL;
      cmd_next   = CMD_WR;
      a_next     = {2'b00, 1'b1, col_reg};
      bao_next   = ba_reg;
    end

    if (state_next != state_reg)
      cnt_next = '0;
  end

  assign load_l = enter_wrl;

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      cmd_reg   <= CMD_NOP;
      a_reg     <= '0;
      bao_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cmd_reg   <= cmd_next;
      a_reg     <= a_next;
      bao_reg   <= bao_next;
      done_reg  <= done_next;
    end
  end

  // Capture registers need no reset: they are only read after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      col_reg   <= col;
      ba_reg    <= ba;
      wdata_reg <= wdata;
    end
  end

`ifdef SDR_WR_DQM_EN
  logic [3:0] be_reg;

  always_ff @(posedge clk) begin
    if (capture)
      be_reg <= wr_be;
  end
`endif

  sdr_wr_dq_drv u_dq_drv (
    .clk       (clk),
    .soft_rst  (soft_rst),
    .load_l    (load_l),
    .load_h    (load_h),
    .wdata     (wdata_reg),
`ifdef SDR_WR_DQM_EN
    .wr_be     (be_reg),
    .sdr_dqm   (sdr_dqm),
`endif
    .sdr_dq_o  (sdr_dq_o),
    .sdr_dq_oe (sdr_dq_oe)
  );

  assign wr_bus  = pack_bus(cmd_reg, a_reg, bao_reg);
  assign wr_done = done_reg;

endmodule

// File: tb/tb_sdr_wr_fsm.sv
// tb_sdr_wr_fsm
//   Directed bench for sdr_wr_fsm. Two instances: dut_d with default
//   timing (2/2/2) and dut_f with 1/1/1. Expected per-cycle outputs are
//   pushed to a queue when a request is driven and popped as the cycles
//   elapse. Cycle k is the interval after the k-th rising edge counted
//   from the edge that samples wr_en (edge 0 starts cycle 1).
module tb_sdr_wr_fsm;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [19:0] BUS_IDLE = {C_NOP, 13'd0, 2'd0, 1'b1};

  typedef struct {
    int          cyc;
    bit          which;
    logic [19:0] bus;
    logic        oe;
    logic [15:0] dq;
    bit          dq_chk;
    logic        done;
    logic [1:0]  dqm;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        soft_rst;
  logic        wr_en_d, wr_en_f;
  logic [12:0] row;
  logic [9:0]  col;
  logic [1:0]  ba;
  logic [31:0] wdata;
  logic [3:0]  wr_be;
  logic        done_d, done_f;
  logic [19:0] bus_d, bus_f;
  logic [15:0] dq_d, dq_f;
  logic        oe_d, oe_f;
  logic [1:0]  dqm_d, dqm_f;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  sdr_wr_fsm dut_d (
    .clk       (clk),
    .soft_rst  (soft_rst),
    .wr_en     (wr_en_d),
    .wr_done   (done_d),
    .row       (row),
    .col       (col),
    .ba        (ba),
    .wdata     (wdata),
`ifdef SDR_WR_DQM_EN
    .wr_be     (wr_be),
    .sdr_dqm   (dqm_d),
`endif
    .wr_bus    (bus_d),
    .sdr_dq_o  (dq_d),
    .sdr_dq_oe (oe_d)
  );

  sdr_wr_fsm #(.T_RCD(1), .T_WR(1), .T_RP(1)) dut_f (
    .clk       (clk),
    .soft_rst  (soft_rst),
    .wr_en     (wr_en_f),
    .wr_done   (done_f),
    .row       (row),
    .col       (col),
    .ba        (ba),
    .wdata     (wdata),
`ifdef SDR_WR_DQM_EN
    .wr_be     (wr_be),
    .sdr_dqm   (dqm_f),
`endif
    .wr_bus    (bus_f),
    .sdr_dq_o  (dq_f),
    .sdr_dq_oe (oe_f)
  );

`ifndef SDR_WR_DQM_EN
  assign dqm_d = 2'b00;
  assign dqm_f = 2'b00;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  // Expected trace of one transaction, cycles t0+1 .. t0+last (the trace
  // ends with the IDLE cycle following wr_done).
  task automatic push_txn(input int t0, input bit which, input int trcd, input int twr,
                          input int trp, input logic [12:0] r, input logic [9:0] c,
                          input logic [1:0] b, input logic [31:0] d, input logic [3:0] be,
                          input int last);
    exp_t e;
    int   len;
    len = 4 + trcd + twr + trp;
    for (int k = 1; k <= len && k <= last; k++) begin
      e.cyc    = t0 + k;
      e.which  = which;
      e.bus    = BUS_IDLE;
      e.oe     = 1'b0;
      e.dq     = d[31:16];
      e.dq_chk = (k >= 2 + trcd);
      e.done   = 1'b0;
      e.dqm    = 2'b00;
      if (k == 1) begin
        e.bus = {C_ACT, r, b, 1'b1};
      end else if (k == 1 + trcd) begin
        e.bus    = {C_WR, 2'b00, 1'b1, c, b, 1'b1};
        e.oe     = 1'b1;
        e.dq     = d[15:0];
        e.dq_chk = 1'b1;
        e.dqm    = ~be[1:0];
      end else if (k == 2 + trcd) begin
        e.oe  = 1'b1;
        e.dqm = ~be[3:2];
      end else if (k == 3 + trcd + twr + trp) begin
        e.done = 1'b1;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic push_idle(input int c, input bit which, input logic [15:0] dq);
    exp_t e;
    e.cyc    = c;
    e.which  = which;
    e.bus    = BUS_IDLE;
    e.oe     = 1'b0;
    e.dq     = dq;
    e.dq_chk = 1'b1;
    e.done   = 1'b0;
    e.dqm    = 2'b00;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk(e.which ? "bus_f" : "bus_d", 32'(e.which ? bus_f : bus_d), 32'(e.bus));
        chk(e.which ? "oe_f" : "oe_d", 32'(e.which ? oe_f : oe_d), 32'(e.oe));
        chk(e.which ? "done_f" : "done_d", 32'(e.which ? done_f : done_d), 32'(e.done));
        if (e.dq_chk)
          chk(e.which ? "dq_f" : "dq_d", 32'(e.which ? dq_f : dq_d), 32'(e.dq));
`ifdef SDR_WR_DQM_EN
        chk(e.which ? "dqm_f" : "dqm_d", 32'(e.which ? dqm_f : dqm_d), 32'(e.dqm));
`endif
      end
    end
  endtask

  task automatic drive_req(input logic [12:0] r, input logic [9:0] c, input logic [1:0] b,
                           input logic [31:0] d, input logic [3:0] be);
    row   = r;
    col   = c;
    ba    = b;
    wdata = d;
    wr_be = be;
  endtask

  initial begin
    soft_rst = 1'b1;
    wr_en_d  = 1'b0;
    wr_en_f  = 1'b0;
    drive_req(13'd0, 10'd0, 2'd0, 32'd0, 4'hF);

    // Reset values on both instances.
    cyc = 0;
    push_idle(2, 1'b0, 16'h0000);
    push_idle(2, 1'b1, 16'h0000);
    step(2);
    soft_rst = 1'b0;
    step(1);
    $display("txn reset: checks=%0d errors=%0d", checks, errors);

    // Single write with default timing.
    drive_req(13'h0123, 10'h2A5, 2'd2, 32'hBEEF_1234, 4'hF);
    wr_en_d = 1'b1;
    cyc = 0;
    push_txn(0, 1'b0, 2, 2, 2, 13'h0123, 10'h2A5, 2'd2, 32'hBEEF_1234, 4'hF, 100);
    step(1);
    wr_en_d = 1'b0;
    step(9);
    $display("txn single write: checks=%0d errors=%0d", checks, errors);

    // Inputs scrambled after acceptance; burst must use captured values.
    drive_req(13'h1ABC, 10'h155, 2'd1, 32'h5A5A_C3C3, 4'hF);
    wr_en_d = 1'b1;
    cyc = 0;
    push_txn(0, 1'b0, 2, 2, 2, 13'h1ABC, 10'h155, 2'd1, 32'h5A5A_C3C3, 4'hF, 100);
    step(1);
    wr_en_d = 1'b0;
    step(1);
    drive_req(13'd0, 10'd0, 2'd0, 32'd0, 4'hF);
    step(8);
    $display("txn captured inputs: checks=%0d errors=%0d", checks, errors);

    // Minimum timing instance: WR directly after ACT, wr_done at cycle 6.
    drive_req(13'h0F0F, 10'h3C3, 2'd3, 32'h1357_9BDF, 4'hF);
    wr_en_f = 1'b1;
    cyc = 0;
    push_txn(0, 1'b1, 1, 1, 1, 13'h0F0F, 10'h3C3, 2'd3, 32'h1357_9BDF, 4'hF, 100);
    step(1);
    wr_en_f = 1'b0;
    step(6);
    $display("txn fast timing: checks=%0d errors=%0d", checks, errors);

    // wr_en held for 30 cycles: ACTs at 1, 11, 21 and nothing in between.
    drive_req(13'h0777, 10'h0AA, 2'd0, 32'hA5A5_0F0F, 4'hF);
    wr_en_d = 1'b1;
    cyc = 0;
    for (int t = 0; t < 30; t += 10)
      push_txn(t, 1'b0, 2, 2, 2, 13'h0777, 10'h0AA, 2'd0, 32'hA5A5_0F0F, 4'hF, 100);
    step(30);
    wr_en_d = 1'b0;
    push_idle(31, 1'b0, 16'hA5A5);
    step(1);
    $display("txn held request x3: checks=%0d errors=%0d", checks, errors);

    // soft_rst during the high-beat cycle abandons the write.
    drive_req(13'h1FFF, 10'h3FF, 2'd3, 32'hCAFE_F00D, 4'hF);
    wr_en_d = 1'b1;
    cyc = 0;
    push_txn(0, 1'b0, 2, 2, 2, 13'h1FFF, 10'h3FF, 2'd3, 32'hCAFE_F00D, 4'hF, 4);
    step(1);
    wr_en_d = 1'b0;
    step(3);
    soft_rst = 1'b1;
    for (int c = 5; c <= 12; c++)
      push_idle(c, 1'b0, 16'h0000);
    step(1);
    soft_rst = 1'b0;
    step(7);
    $display("txn reset mid-burst: checks=%0d errors=%0d", checks, errors);

    // Write after the abandoned one completes normally; partial byte enables.
    drive_req(13'h0A0A, 10'h001, 2'd1, 32'h8765_4321, 4'b0110);
    wr_en_d = 1'b1;
    cyc = 0;
    push_txn(0, 1'b0, 2, 2, 2, 13'h0A0A, 10'h001, 2'd1, 32'h8765_4321, 4'b0110, 100);
    step(1);
    wr_en_d = 1'b0;
    step(9);
    $display("txn after reset with wr_be=0110: checks=%0d errors=%0d", checks, errors);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
